// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-memory requests, waits on the
// ready handshake, aligns store data/masks and extracts loads into MEM/WB.
module mem_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_reg,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_alu_res,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_dmem_req,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  output logic        o_stall,
  output logic        o_vld,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata,
  output logic        o_misaligned
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t r_state, w_state_nxt;

  function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Fields captured when a request has to wait; the stage then runs from
  // these copies and ignores whatever upstream is holding.
  logic [31:0] r_addr_p0, r_wdata_p0, r_alu_p0;
  logic [2:0]  r_f3_p0;
  logic        r_read_p0, r_write_p0, r_mem_reg_p0, r_rd_wen_p0;
  logic [4:0]  r_rd_waddr_p0;

  logic        r_vld_p1, r_rd_wen_p1, r_mis_p1;
  logic [4:0]  r_rd_waddr_p1;
  logic [31:0] r_rd_wdata_p1;

  logic        w_access, w_legal, w_req, w_done, w_in_wait;
  logic [31:0] w_sel_addr, w_sel_wdata, w_sel_alu, w_wb_data;
  logic [2:0]  w_sel_f3;
  logic        w_sel_read, w_sel_write, w_sel_mem_reg, w_sel_rd_wen;
  logic [4:0]  w_sel_rd_waddr;

  assign w_access  = i_vld & (i_mem_read | i_mem_write);
  assign w_in_wait = (r_state == WAIT);

  always_comb begin
    w_legal = 1'b0;
    if (i_mem_read) begin
      case (i_funct3)
        3'b000, 3'b100: w_legal = 1'b1;
        3'b001, 3'b101: w_legal = ~i_addr[0];
        3'b010:         w_legal = (i_addr[1:0] == 2'b00);
        default:        w_legal = 1'b0;
      endcase
    end else begin
      case (i_funct3)
        3'b000:  w_legal = 1'b1;
        3'b001:  w_legal = ~i_addr[0];
        3'b010:  w_legal = (i_addr[1:0] == 2'b00);
        default: w_legal = 1'b0;
      endcase
    end
  end

  assign w_sel_addr     = w_in_wait ? r_addr_p0     : i_addr;
  assign w_sel_wdata    = w_in_wait ? r_wdata_p0    : i_wdata;
  assign w_sel_alu      = w_in_wait ? r_alu_p0      : i_alu_res;
  assign w_sel_f3       = w_in_wait ? r_f3_p0       : i_funct3;
  assign w_sel_read     = w_in_wait ? r_read_p0     : i_mem_read;
  assign w_sel_write    = w_in_wait ? r_write_p0    : (i_mem_write & ~i_mem_read);
  assign w_sel_mem_reg  = w_in_wait ? r_mem_reg_p0  : i_mem_reg;
  assign w_sel_rd_wen   = w_in_wait ? r_rd_wen_p0   : i_rd_wen;
  assign w_sel_rd_waddr = w_in_wait ? r_rd_waddr_p0 : i_rd_waddr;

  assign w_req  = ~i_rst & (w_in_wait | (w_access & w_legal));
  assign w_done = w_req & i_dmem_ready;

  assign w_wb_data = w_sel_mem_reg ? load_ext(w_sel_f3, w_sel_addr[1:0], i_dmem_rdata)
                                   : w_sel_alu;

  assign o_dmem_req   = w_req;
  assign o_stall      = w_req & ~i_dmem_ready;
  assign o_dmem_wen   = w_req & w_sel_write;
  assign o_dmem_addr  = {w_sel_addr[31:2], 2'b00};
  assign o_dmem_mask  = w_sel_read ? 4'b1111 : store_mask(w_sel_f3[1:0], w_sel_addr[1:0]);
  assign o_dmem_wdata = store_data(w_sel_f3[1:0], w_sel_wdata);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req && !i_dmem_ready) w_state_nxt = WAIT;
      WAIT:    if (i_dmem_ready)           w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---- p0: request capture on entry to WAIT ----
  always_ff @(posedge i_clk) begin
    if (!w_in_wait && w_req && !i_dmem_ready) begin
      r_addr_p0     <= i_addr;
      r_wdata_p0    <= i_wdata;
      r_alu_p0      <= i_alu_res;
      r_f3_p0       <= i_funct3;
      r_read_p0     <= i_mem_read;
      r_write_p0    <= i_mem_write & ~i_mem_read;
      r_mem_reg_p0  <= i_mem_reg;
      r_rd_wen_p0   <= i_rd_wen;
      r_rd_waddr_p0 <= i_rd_waddr;
    end
  end

  // ---- p1: MEM/WB register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p1      <= 1'b0;
      r_rd_wen_p1   <= 1'b0;
      r_mis_p1      <= 1'b0;
      r_rd_waddr_p1 <= 5'd0;
      r_rd_wdata_p1 <= 32'd0;
    end else begin
      r_vld_p1    <= 1'b0;
      r_rd_wen_p1 <= 1'b0;
      r_mis_p1    <= 1'b0;
      if (w_done) begin
        r_vld_p1      <= 1'b1;
        r_rd_wen_p1   <= w_sel_rd_wen;
        r_rd_waddr_p1 <= w_sel_rd_waddr;
        r_rd_wdata_p1 <= w_wb_data;
      end else if (!w_in_wait && i_vld && !w_access) begin
        r_vld_p1      <= 1'b1;
        r_rd_wen_p1   <= i_rd_wen;
        r_rd_waddr_p1 <= i_rd_waddr;
        r_rd_wdata_p1 <= i_alu_res;
      end else if (!w_in_wait && w_access && !w_legal) begin
        r_vld_p1      <= 1'b1;
        r_mis_p1      <= 1'b1;
        r_rd_waddr_p1 <= i_rd_waddr;
        r_rd_wdata_p1 <= i_alu_res;
      end
    end
  end

  assign o_vld        = r_vld_p1;
  assign o_rd_wen     = r_rd_wen_p1;
  assign o_misaligned = r_mis_p1;
  assign o_rd_waddr   = r_rd_waddr_p1;
  assign o_rd_wdata   = r_rd_wdata_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level reference model,
// plus directed scenarios for the documented corner cases.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        i_rst, i_vld, i_mem_read, i_mem_write, i_mem_reg, i_rd_wen, i_dmem_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, i_alu_res, i_dmem_rdata;
  logic [4:0]  i_rd_waddr;
  logic        o_dmem_req, o_dmem_wen, o_stall, o_vld, o_rd_wen, o_misaligned;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_rd_wdata;
  logic [3:0]  o_dmem_mask;
  logic [4:0]  o_rd_waddr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_mem_reg(i_mem_reg), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_alu_res(i_alu_res),
    .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_dmem_ready(i_dmem_ready),
    .i_dmem_rdata(i_dmem_rdata), .o_dmem_req(o_dmem_req), .o_dmem_wen(o_dmem_wen),
    .o_dmem_addr(o_dmem_addr), .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
    .o_stall(o_stall), .o_vld(o_vld), .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr),
    .o_rd_wdata(o_rd_wdata), .o_misaligned(o_misaligned)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference model: access size in bytes and plain arithmetic on it.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit rd, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    if (rd) ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else    ok = (f3 == 0 || f3 == 1 || f3 == 2);
    return ok && ((a % m_size(f3)) == 0);
  endfunction

  function automatic logic [31:0] m_mask(input bit rd, input logic [2:0] f3, input logic [31:0] a);
    int m;
    if (rd) return 32'd15;
    m = ((1 << m_size(f3)) - 1) << (a % 4);
    return 32'(m & 15);
  endfunction

  function automatic logic [31:0] m_sdata(input logic [2:0] f3, input logic [31:0] d);
    longint v, rep;
    int sz;
    sz  = m_size(f3);
    v   = longint'(d) & ((64'd1 << (8 * sz)) - 1);
    rep = (sz == 1) ? 64'h01010101 : (sz == 2) ? 64'h00010001 : 64'd1;
    return 32'(v * rep);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    longint v;
    int sz;
    sz = m_size(f3);
    v  = (longint'(w) >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1);
    if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return 32'(v);
  endfunction

  // Drive one instruction (held while stalled), play the memory side with
  // the given wait count, and check request, stall and writeback.
  task automatic run(input bit vld, input bit rd, input bit wr, input bit mr,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] alu, input logic [4:0] rda, input bit wen,
                     input int waits, input logic [31:0] rdata);
    bit acc, legal;
    i_vld = vld; i_mem_read = rd; i_mem_write = wr; i_mem_reg = mr; i_funct3 = f3;
    i_addr = a; i_wdata = wd; i_alu_res = alu; i_rd_waddr = rda; i_rd_wen = wen;
    acc   = vld && (rd || wr);
    legal = m_legal(rd, f3, a);
    if (acc && legal) begin
      for (int j = 0; j <= waits; j++) begin
        i_dmem_ready = (j == waits);
        i_dmem_rdata = (j == waits) ? rdata : $urandom;
        @(negedge clk);
        check("req", 32'(o_dmem_req), 32'd1);
        check("stall", 32'(o_stall), 32'(j != waits));
        check("daddr", o_dmem_addr, {a[31:2], 2'b00});
        check("mask", 32'(o_dmem_mask), m_mask(rd, f3, a));
        check("dwen", 32'(o_dmem_wen), 32'(wr && !rd));
        if (wr && !rd) check("dwdata", o_dmem_wdata, m_sdata(f3, wd));
        @(posedge clk); #1;
        if (j != waits) check("bubble_vld", 32'(o_vld), 32'd0);
      end
      check("wb_vld", 32'(o_vld), 32'd1);
      check("wb_wen", 32'(o_rd_wen), 32'(wen));
      check("wb_waddr", 32'(o_rd_waddr), 32'(rda));
      check("wb_wdata", o_rd_wdata, mr ? m_load(f3, a, rdata) : alu);
      check("wb_mis", 32'(o_misaligned), 32'd0);
    end else begin
      i_dmem_ready = 1'($urandom);
      i_dmem_rdata = $urandom;
      @(negedge clk);
      check("noreq", 32'(o_dmem_req), 32'd0);
      check("nostall", 32'(o_stall), 32'd0);
      @(posedge clk); #1;
      if (!vld) begin
        check("bub_vld", 32'(o_vld), 32'd0);
        check("bub_wen", 32'(o_rd_wen), 32'd0);
        check("bub_mis", 32'(o_misaligned), 32'd0);
      end else if (acc) begin
        check("ill_vld", 32'(o_vld), 32'd1);
        check("ill_wen", 32'(o_rd_wen), 32'd0);
        check("ill_mis", 32'(o_misaligned), 32'd1);
      end else begin
        check("alu_vld", 32'(o_vld), 32'd1);
        check("alu_wen", 32'(o_rd_wen), 32'(wen));
        check("alu_waddr", 32'(o_rd_waddr), 32'(rda));
        check("alu_wdata", o_rd_wdata, alu);
        check("alu_mis", 32'(o_misaligned), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    bit rd, wr;
    i_rst = 1'b1; i_vld = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_mem_reg = 1'b1;
    i_funct3 = 3'b010; i_addr = 32'h100; i_wdata = 32'd0; i_alu_res = 32'd0;
    i_rd_waddr = 5'd1; i_rd_wen = 1'b1; i_dmem_ready = 1'b0; i_dmem_rdata = 32'd0;

    // Reset: request suppressed even with a legal access presented.
    @(negedge clk);
    check("rst_req", 32'(o_dmem_req), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_vld", 32'(o_vld), 32'd0);
    check("rst_wen", 32'(o_rd_wen), 32'd0);
    check("rst_mis", 32'(o_misaligned), 32'd0);
    check("rst_waddr", 32'(o_rd_waddr), 32'd0);
    check("rst_wdata", o_rd_wdata, 32'd0);
    i_rst = 1'b0;

    // LB at 0x103, zero wait.
    run(1, 1, 0, 1, 3'b000, 32'h103, 32'd0, 32'h55, 5'd3, 1, 0, 32'h80AABBCC);
    check("lb_const", o_rd_wdata, 32'hFFFFFF80);
    // SH at 0x202, two waits.
    run(1, 0, 1, 0, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 5'd0, 0, 2, 32'd0);
    // LW at 0x006: misaligned.
    run(1, 1, 0, 1, 3'b010, 32'h006, 32'd0, 32'h0, 5'd4, 1, 0, 32'd0);
    // LW with one wait followed directly by an ALU op.
    run(1, 1, 0, 1, 3'b010, 32'h40, 32'd0, 32'h0, 5'd6, 1, 1, 32'h11);
    run(1, 0, 0, 0, 3'b000, 32'h0, 32'd0, 32'h42, 5'd5, 1, 0, 32'd0);

    // LHU at 0 with reset asserted during the second wait cycle.
    i_vld = 1; i_mem_read = 1; i_mem_write = 0; i_mem_reg = 1; i_funct3 = 3'b101;
    i_addr = 32'h0; i_rd_waddr = 5'd7; i_rd_wen = 1; i_dmem_ready = 0;
    @(negedge clk);
    check("r21_req0", 32'(o_dmem_req), 32'd1);
    check("r21_stall0", 32'(o_stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("r21_req1", 32'(o_dmem_req), 32'd1);
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(negedge clk);
    check("r21_req_rst", 32'(o_dmem_req), 32'd0);
    check("r21_stall_rst", 32'(o_stall), 32'd0);
    @(posedge clk); #1;
    check("r21_vld", 32'(o_vld), 32'd0);
    check("r21_wdata", o_rd_wdata, 32'd0);
    i_rst = 1'b0; i_vld = 1'b0; i_dmem_ready = 1'b1; i_dmem_rdata = 32'h0000F00D;
    @(negedge clk);
    check("r21_idle_req", 32'(o_dmem_req), 32'd0);
    @(posedge clk); #1;
    check("r21_nowb", 32'(o_vld), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      rd = 1'($urandom);
      wr = 1'($urandom);
      run($urandom_range(0, 7) != 0, rd, wr, rd ? 1'($urandom) : 1'b0,
          3'($urandom), a, $urandom, $urandom, 5'($urandom), 1'($urandom),
          $urandom_range(0, 3), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL use one clock and a synchronous, active-high reset: i_clk, i_rst.
REQ-003 Ports, listed as name  direction  width  meaning:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_vld  in  1  EX/MEM entry holds a real instruction.
- i_mem_read  in  1  load.
- i_mem_write  in  1  store.
- i_mem_reg  in  1  writeback selects load data, not ALU result.
- i_funct3  in  3  access size/sign.
- i_addr  in  32  byte address (ALU result).
- i_wdata  in  32  store data (rs2).
- i_alu_res  in  32  non-load writeback value.
- i_rd_waddr  in  5  destination register.
- i_rd_wen  in  1  destination write enable.
- i_dmem_ready  in  1  memory completes the request this cycle.
- i_dmem_rdata  in  32  read word, valid when ready.
- o_dmem_req  out  1  access request.
- o_dmem_wen  out  1  request is a store.
- o_dmem_addr  out  32  word address, {addr[31:2],2'b00}.
- o_dmem_mask  out  4  byte enables.
- o_dmem_wdata  out  32  lane-aligned store data.
- o_stall  out  1  upstream must hold.
- o_vld, o_rd_wen  out  1 each  MEM/WB registered.
- o_rd_waddr  out  5  MEM/WB registered.
- o_rd_wdata  out  32  MEM/WB registered.
- o_misaligned  out  1  registered one-cycle trap pulse.

Function
REQ-004 access = i_vld & (i_mem_read | i_mem_write); both high SHALL perform the read only.
REQ-005 FSM states: IDLE, WAIT.
- IDLE with access and legal alignment: o_dmem_req=1 in the same cycle, driven from the inputs.
- If i_dmem_ready=1 that cycle: complete with zero wait, stay IDLE.
- Otherwise: latch addr, wdata, funct3, read/write, mem_reg, rd fields; go to WAIT.
REQ-006 WAIT: o_dmem_req=1, driven from the latched fields; on i_dmem_ready go to IDLE; otherwise stay.
REQ-007 o_stall = o_dmem_req & ~i_dmem_ready (combinational); upstream holds its inputs while stalled.
REQ-008 i_dmem_ready while o_dmem_req=0 SHALL be ignored.
REQ-009 Byte offset off=addr[1:0]. Store mask by funct3:
- SB: 4'b0001<<off, data byte replicated x4.
- SH: 4'b0011<<off, data half replicated x2.
- SW: 4'b1111, data unchanged.
- Loads: mask 4'b1111.
REQ-010 Load extract: the byte/half at off from i_dmem_rdata.
- 000 LB, 001 LH: sign-extended.
- 100 LBU, 101 LHU: zero-extended.
- 010 LW: whole word.
REQ-011 Illegal access SHALL issue no request and SHALL NOT stall:
- half with addr[0]=1;
- word with addr[1:0]!=0;
- load funct3 in {011,110,111};
- store funct3 not in {000,001,010}.
REQ-012 For an illegal access, next cycle: o_misaligned=1, o_vld=1, o_rd_wen=0.
REQ-013 MEM/WB register update each cycle:
- Non-access instruction: pass through; o_rd_wdata=i_alu_res.
- Access completion: o_rd_wdata = i_mem_reg ? extended load : alu_res (latched copies if completing from WAIT).
- Stall cycle: bubble (o_vld=0, o_rd_wen=0, o_misaligned=0).
- i_vld=0: bubble.
REQ-014 Latency: zero-wait load data SHALL appear on o_rd_wdata one cycle after the request; with N wait cycles, N+1 cycles after.

Reset
REQ-015 i_rst SHALL force, at the next edge:
- state=IDLE;
- o_vld, o_rd_wen, o_misaligned = 0;
- o_rd_waddr = 0; o_rd_wdata = 0.
REQ-016 While i_rst=1, o_dmem_req and o_stall SHALL be 0.
REQ-017 Reset during WAIT SHALL abandon the access; no writeback for it.

Verification
REQ-018 LB at addr 0x103, rdata 0x80AABBCC, ready same cycle -> no stall; next cycle o_rd_wdata=0xFFFFFF80, o_vld=1.
REQ-019 SH at 0x202, wdata 0x1234ABCD, ready after 2 wait cycles -> o_dmem_addr=0x200, mask 4'b1100, wdata 0xABCDABCD; o_stall high 2 cycles; bubbles during stall.
REQ-020 LW at 0x006 -> no req, no stall; next cycle o_misaligned=1, o_rd_wen=0.
REQ-021 LHU at 0x000, rdata 0x0000F00D after 3 waits, i_rst asserted in 2nd wait -> req drops, o_vld=0, state IDLE, no writeback.
REQ-022 ALU op (rd=5, res=0x42) directly following a 1-wait LW (rd=6, rdata 0x11) -> o_rd_waddr 6/0x11 then 5/0x42 in consecutive cycles; no lost or duplicated writeback.
